mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the 16x32 data-memory port: accepts load/store requests from the core via valid/ready and drives the memory's address, writeEnable and writeData.
- Captures the memory's registered read data and returns responses via valid/ready.
- Memory timing is fixed: memory writes on the negedge while write enable is high; memory registers read data on the posedge from the current address.
- Sits between the execute stage and the data memory; one request outstanding at a time.

Parameters:
- ADDR_W, 4, memory word-address width (depth = 2**ADDR_W words).
- DATA_W, 32, memory word width; must be 32.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned for sub-word sizes.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  32  load data, zero-extended; 0 for stores and errors.
- resp_err  out  1  request rejected; memory untouched.
- mem_addr  out  ADDR_W  to memory address.
- mem_we  out  1  to memory writeEnable.
- mem_wdata  out  32  to memory writeData.
- mem_rdata  in  32  from memory data.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_addr=0; mem_we=0; mem_wdata=0. Reset aborts any operation in flight in any state. mem_we deasserts at that same edge, so no write is issued after reset.
- All outputs are registered.
- Handshake: a request is accepted when req_valid & req_ready at a posedge. A response is retired when resp_valid & resp_ready. resp_valid and all resp_* hold stable until retired.
- req_ready=1 only in IDLE. The cycle a response retires, state returns to IDLE; a new request is accepted no earlier than the following edge.
- Error check at acceptance:
  - size 3 → err.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) → err.
  - addr[31:ADDR_W+2] != 0 → err.
  - Sizes other than word when BYTE_SIZE_EN is undefined → err.
  - Error path: go directly to RESP with resp_err=1 next cycle; mem_we stays 0.
- Word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0].
- States: IDLE, RD_WAIT, RD_CAP, WR, RESP.
- Load (accept at edge E0):
  - E0: mem_addr←index; → RD_WAIT.
  - E1: memory registers the word; → RD_CAP.
  - E2: extract lane from mem_rdata, zero-extend into resp_rdata; resp_valid=1; → RESP.
  - Response visible 2 cycles after acceptance.
- Word store (accept at E0):
  - E0: mem_addr←index, mem_wdata←req_wdata, mem_we←1; → WR.
  - The memory write occurs on the negedge inside this cycle.
  - E1: mem_we←0, resp_valid=1, resp_rdata=0; → RESP.
- Sub-word store (feature only): RMW.
  - Perform the load sequence to RD_CAP.
  - At E2: merge the shifted req_wdata bytes into mem_rdata; mem_wdata←merged; mem_we←1; → WR.
  - Then proceed as for a word store.
  - Non-addressed bytes of the word are unchanged.
- mem_we is high for exactly one cycle per store and never during loads or errors.
- mem_addr holds its last value when idle.
- RESP with resp_ready=0: hold indefinitely; no memory activity.

Optional Feature:
- Macro: MEM_ACCESS_BYTE_SIZE_EN.
- Defined: byte/half loads (lane extract, zero-extend) and byte/half stores via read-modify-write. Sub-word store latency is 3 cycles to resp_valid.
- Undefined: only size 2 is legal; size 0/1 returns resp_err=1 with no memory access. Merge/extract logic is absent.

Decomposition:
- Package mem_access_pkg:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state_e (IDLE, RD_WAIT, RD_CAP, WR, RESP).
  - Constant MEM_DEPTH = 2**ADDR_W.
- Sub-module lane_merge: combinational.
  - Inputs: size, lane, old word, new data.
  - Outputs: merged word and extracted/zero-extended load value.
  - Instantiated only under the macro.

Test Plan:
- Store word 0xDEADBEEF @0x08, then load word @0x08 → mem_we high one cycle with mem_addr=2; load resp_rdata=0xDEADBEEF two cycles after acceptance; resp_err=0.
- Load @0x40 (out of range, ADDR_W=4) and word load @0x06 (misaligned) → resp_err=1 next cycle, resp_rdata=0, mem_we never asserted.
- Feature on:
  - Word 0x11223344 stored @0x0C.
  - Byte store 0xAA @0x0D → word reads back 0x1122AA44.
  - Byte load @0x0F → 0x00000011.
  - Half load @0x0E → 0x00001122.
- Feature off: byte store @0x0C → resp_err=1; word @0x0C unchanged.
- Backpressure: resp_ready=0 for 5 cycles after load response → resp_valid/resp_rdata stable, req_ready=0, mem_we=0 throughout; retire, then back-to-back request accepted the cycle after retire.
- Reset asserted in WR cycle of a store and in RD_CAP of a load → next cycle all outputs at reset values, no resp_valid. A subsequent load of an untouched address returns its initial contents.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory initiator (mem_access_unit).
package mem_access_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int MEM_DEPTH  = 2 ** DEF_ADDR_W;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_CAP  = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response bundle and memory-side port bundle for mem_access_unit.

// Handshake: a request or response transfers on a rising clk edge where valid and
// ready are both high; the sender holds valid and its payload stable until then.
interface mem_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface mem_bus_if #(parameter int ADDR_W = 4);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (output mem_addr, mem_we, mem_wdata, input mem_rdata);
   modport slave  (input mem_addr, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_access_unit_lane_merge.sv
// Byte/half lane merge for read-modify-write stores and lane extract for loads.
// Only built with MEM_ACCESS_BYTE_SIZE_EN.
`ifdef MEM_ACCESS_BYTE_SIZE_EN
module lane_merge
   import mem_access_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   output logic [31:0] merged,
   output logic [31:0] load_val
);

   logic [4:0]  sh;
   logic [31:0] mask;

   always_comb begin
      sh   = 5'd0;
      mask = 32'hFFFF_FFFF;
      case (size)
         SZ_BYTE: begin
            sh   = {lane, 3'b000};
            mask = 32'h0000_00FF << sh;
         end
         SZ_HALF: begin
            sh   = {lane[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
         end
         default: begin
            sh   = 5'd0;
            mask = 32'hFFFF_FFFF;
         end
      endcase
      merged   = (old_word & ~mask) | ((new_data << sh) & mask);
      load_val = (old_word & mask) >> sh;
   end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Load/store initiator for a 2**ADDR_W x 32 memory with negedge writes and registered reads.
// Optional MEM_ACCESS_BYTE_SIZE_EN adds byte/half loads and read-modify-write sub-word stores.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic      clk,
   input  logic      rst,
   mem_req_if.slave  req,
   mem_bus_if.master mem,
   output state_e    state_dbg
);

   state_e             state;
   logic               req_bad;
   logic [ADDR_W-1:0]  req_idx;
   logic [DATA_W-1:0]  load_val;
   logic [DATA_W-1:0]  merged_word;
   logic               rmw_store;

   assign state_dbg = state;
   assign req_idx   = req.req_addr[ADDR_W+1:2];

   always_comb begin
      req_bad = 1'b0;
      if (req.req_size == 2'd3) req_bad = 1'b1;
      if (req.req_size == SZ_HALF && req.req_addr[0]) req_bad = 1'b1;
      if (req.req_size == SZ_WORD && req.req_addr[1:0] != 2'b00) req_bad = 1'b1;
      if (req.req_addr[31:ADDR_W+2] != '0) req_bad = 1'b1;
`ifndef MEM_ACCESS_BYTE_SIZE_EN
      if (req.req_size != SZ_WORD) req_bad = 1'b1;
`endif
   end

`ifdef MEM_ACCESS_BYTE_SIZE_EN
   logic        op_we;
   size_e       op_size;
   logic [1:0]  op_lane;
   logic [31:0] op_wdata;

   // Request fields are needed again two edges later for extract/merge.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_we    <= 1'b0;
         op_size  <= SZ_WORD;
         op_lane  <= 2'b00;
         op_wdata <= 32'h0;
      end else if (state == IDLE && req.req_valid) begin
         op_we    <= req.req_we;
         op_size  <= size_e'(req.req_size);
         op_lane  <= req.req_addr[1:0];
         op_wdata <= req.req_wdata;
      end
   end

   lane_merge u_lane_merge (
      .size     (op_size),
      .lane     (op_lane),
      .old_word (mem.mem_rdata),
      .new_data (op_wdata),
      .merged   (merged_word),
      .load_val (load_val)
   );

   assign rmw_store = op_we;
`else
   assign load_val    = mem.mem_rdata;
   assign merged_word = mem.mem_rdata;
   assign rmw_store   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         req.req_ready  <= 1'b1;
         req.resp_valid <= 1'b0;
         req.resp_err   <= 1'b0;
         req.resp_rdata <= 32'h0;
         mem.mem_addr   <= '0;
         mem.mem_we     <= 1'b0;
         mem.mem_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req.req_valid) begin
                  req.req_ready <= 1'b0;
                  if (req_bad) begin
                     req.resp_valid <= 1'b1;
                     req.resp_err   <= 1'b1;
                     req.resp_rdata <= 32'h0;
                     state          <= RESP;
                  end else begin
                     mem.mem_addr <= req_idx;
                     if (req.req_we && req.req_size == SZ_WORD) begin
                        mem.mem_wdata <= req.req_wdata;
                        mem.mem_we    <= 1'b1;
                        state         <= WR;
                     end else begin
                        state <= RD_WAIT;
                     end
                  end
               end
            end
            // Memory samples mem_addr on this edge; its data is ready for RD_CAP.
            RD_WAIT: state <= RD_CAP;
            RD_CAP: begin
               if (rmw_store) begin
                  mem.mem_wdata <= merged_word;
                  mem.mem_we    <= 1'b1;
                  state         <= WR;
               end else begin
                  req.resp_valid <= 1'b1;
                  req.resp_err   <= 1'b0;
                  req.resp_rdata <= load_val;
                  state          <= RESP;
               end
            end
            WR: begin
               mem.mem_we     <= 1'b0;
               req.resp_valid <= 1'b1;
               req.resp_err   <= 1'b0;
               req.resp_rdata <= 32'h0;
               state          <= RESP;
            end
            RESP: begin
               if (req.resp_ready) begin
                  req.resp_valid <= 1'b0;
                  req.resp_err   <= 1'b0;
                  req.resp_rdata <= 32'h0;
                  req.req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: begin
               mem.mem_we    <= 1'b0;
               req.req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural 16x32 memory and a reference model.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   localparam int ADDR_W = 4;
`ifdef MEM_ACCESS_BYTE_SIZE_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_req_if                    req_if ();
   mem_bus_if #(.ADDR_W(ADDR_W)) bus_if ();
   state_e                       state_dbg;

   mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req_if),
      .mem       (bus_if),
      .state_dbg (state_dbg)
   );

   // behavioural memory: negedge write, posedge registered read
   logic        mem_init = 1'b1;
   logic [31:0] mem_array [MEM_DEPTH];
   logic [31:0] ref_mem   [MEM_DEPTH];

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {8'h10 + b, 8'h20 + b, 8'h30 + b, 8'h40 + b};
   endfunction

   always @(negedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem_array[i] <= init_word(i);
      end else if (bus_if.mem_we === 1'b1) begin
         mem_array[bus_if.mem_addr] <= bus_if.mem_wdata;
      end
   end

   always @(posedge clk) bus_if.mem_rdata <= mem_array[bus_if.mem_addr];

   // write-enable monitor
   int                we_total = 0;
   logic [ADDR_W-1:0] we_addr_last = '0;
   always @(negedge clk) begin
      if (bus_if.mem_we === 1'b1) begin
         we_total     <= we_total + 1;
         we_addr_last <= bus_if.mem_addr;
      end
   end

   // scoreboard state
   int                checks   = 0;
   int                failures = 0;
   int                we_base  = 0;
   logic [32:0]       exp_q [$];
   int                lat_q [$];
   int                we_q  [$];
   logic [ADDR_W-1:0] wa_q  [$];

   // driver: must be entered at a negedge; returns at the negedge after acceptance
   task automatic drive_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit track, output int waited);
      logic              err;
      logic [31:0]       w;
      logic [31:0]       exp_data;
      logic [ADDR_W-1:0] idx;
      int                lane;
      int                sh;
      int                n;
      err = (size == 2'd3) || (addr[31:ADDR_W+2] != '0) ||
            (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00) ||
            (!FEAT && size != 2'd2);
      idx      = addr[ADDR_W+1:2];
      lane     = int'(addr[1:0]);
      sh       = lane * 8;
      w        = ref_mem[idx];
      exp_data = 32'h0;
      if (!err) begin
         if (!we) begin
            case (size)
               2'd0:    exp_data = (w >> sh) & 32'h0000_00FF;
               2'd1:    exp_data = (w >> sh) & 32'h0000_FFFF;
               default: exp_data = w;
            endcase
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (size == 2'd2 || (b >= lane && b < lane + ((size == 2'd1) ? 2 : 1)))
                  w[b*8 +: 8] = wdata[(b - lane)*8 +: 8];
            end
            ref_mem[idx] = w;
         end
      end
      if (track) begin
         exp_q.push_back({err, exp_data});
         lat_q.push_back(err ? 0 : (!we ? 2 : ((size == 2'd2) ? 1 : 3)));
         we_q.push_back((!err && we) ? 1 : 0);
         wa_q.push_back(idx);
      end
      n = 0;
      while (req_if.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      checks++;
      if (req_if.req_ready !== 1'b1)
         begin failures++; $display("FAIL req_ready_timeout got=%b exp=1", req_if.req_ready); end
      we_base           = we_total;
      req_if.req_we     = we;
      req_if.req_size   = size;
      req_if.req_addr   = addr;
      req_if.req_wdata  = wdata;
      req_if.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_if.req_valid  = 1'b0;
   endtask

   // scoreboard: pops one expected response and checks it; returns at the negedge after retire
   task automatic collect_resp(input int hold);
      logic [32:0]       exp;
      logic [32:0]       got;
      int                exp_lat;
      int                exp_we;
      logic [ADDR_W-1:0] exp_wa;
      int                lat;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=0 exp=1");
         return;
      end
      exp     = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      exp_we  = we_q.pop_front();
      exp_wa  = wa_q.pop_front();
      req_if.resp_ready = (hold == 0);
      lat = 0;
      while (req_if.resp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != exp_lat)
         begin failures++; $display("FAIL resp_latency got=%0d exp=%0d", lat, exp_lat); end
      got = {req_if.resp_err, req_if.resp_rdata};
      checks++;
      if (got !== exp)
         begin failures++; $display("FAIL resp_data got=%h exp=%h", got, exp); end
      checks++;
      if (req_if.req_ready !== 1'b0)
         begin failures++; $display("FAIL req_ready_in_resp got=%b exp=0", req_if.req_ready); end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if ({req_if.resp_valid, req_if.req_ready, bus_if.mem_we, req_if.resp_err, req_if.resp_rdata}
             !== {3'b100, exp})
            begin
               failures++;
               $display("FAIL resp_hold cyc=%0d got=%b/%b/%b/%h exp=1/0/0/%h", i, req_if.resp_valid,
                        req_if.req_ready, bus_if.mem_we, {req_if.resp_err, req_if.resp_rdata}, exp);
            end
      end
      req_if.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_if.resp_valid, req_if.req_ready} !== 2'b01)
         begin failures++; $display("FAIL retire got=%b%b exp=01", req_if.resp_valid, req_if.req_ready); end
      checks++;
      if (we_total - we_base != exp_we)
         begin failures++; $display("FAIL we_pulses got=%0d exp=%0d", we_total - we_base, exp_we); end
      if (exp_we == 1) begin
         checks++;
         if (we_addr_last !== exp_wa)
            begin failures++; $display("FAIL we_addr got=%0d exp=%0d", we_addr_last, exp_wa); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({state_dbg, req_if.req_ready, req_if.resp_valid, req_if.resp_err, req_if.resp_rdata,
           bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata} !==
          {IDLE, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0})
         begin failures++; $display("FAIL reset_values state=%0d rdy=%b rv=%b we=%b", state_dbg,
                                    req_if.req_ready, req_if.resp_valid, bus_if.mem_we); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({state_dbg, req_if.req_ready, req_if.resp_valid, bus_if.mem_we} !== {IDLE, 3'b100})
         begin failures++; $display("FAIL idle_after_reset state=%0d rdy=%b rv=%b we=%b exp=0/1/0/0",
                                    state_dbg, req_if.req_ready, req_if.resp_valid, bus_if.mem_we); end
   endtask

   task automatic test_word_store_load();
      int waited;
      drive_req(1'b1, 2'd2, 32'h08, 32'hDEAD_BEEF, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b0, 2'd2, 32'h08, 32'h0, 1'b1, waited);
      collect_resp(0);
   endtask

   task automatic test_errors();
      int waited;
      drive_req(1'b0, 2'd2, 32'h40, 32'h0, 1'b1, waited);            // out of range
      collect_resp(0);
      drive_req(1'b0, 2'd2, 32'h06, 32'h0, 1'b1, waited);            // misaligned word
      collect_resp(0);
      drive_req(1'b0, 2'd3, 32'h00, 32'h0, 1'b1, waited);            // illegal size
      collect_resp(0);
      drive_req(1'b1, 2'd2, 32'h100, 32'h1234_5678, 1'b1, waited);   // out-of-range store
      collect_resp(0);
      drive_req(1'b0, 2'd1, 32'h01, 32'h0, 1'b1, waited);            // misaligned half
      collect_resp(0);
      drive_req(1'b1, 2'd0, 32'h0C, 32'h0000_00AA, 1'b1, waited);    // gated without the feature
      collect_resp(0);
      drive_req(1'b0, 2'd2, 32'h0C, 32'h0, 1'b1, waited);
      collect_resp(0);
   endtask

`ifdef MEM_ACCESS_BYTE_SIZE_EN
   task automatic test_byte_size();
      int waited;
      drive_req(1'b1, 2'd2, 32'h0C, 32'h1122_3344, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b1, 2'd0, 32'h0D, 32'h0000_00AA, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b0, 2'd2, 32'h0C, 32'h0, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b0, 2'd0, 32'h0F, 32'h0, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b0, 2'd1, 32'h0E, 32'h0, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b1, 2'd1, 32'h02, 32'h0000_BEEF, 1'b1, waited);
      collect_resp(0);
      drive_req(1'b0, 2'd2, 32'h00, 32'h0, 1'b1, waited);
      collect_resp(0);
   endtask
`endif

   task automatic test_backpressure();
      int waited;
      drive_req(1'b0, 2'd2, 32'h08, 32'h0, 1'b1, waited);
      collect_resp(5);
      drive_req(1'b0, 2'd2, 32'h0C, 32'h0, 1'b1, waited);
      checks++;
      if (waited != 0)
         begin failures++; $display("FAIL back_to_back_wait got=%0d exp=0", waited); end
      collect_resp(0);
   endtask

   task automatic test_reset_midflight();
      int waited;
      drive_req(1'b1, 2'd2, 32'h14, 32'hCAFE_F00D, 1'b0, waited);
      checks++;
      if ({state_dbg, bus_if.mem_we} !== {WR, 1'b1})
         begin failures++; $display("FAIL in_wr got=%0d/%b exp=%0d/1", state_dbg, bus_if.mem_we, WR); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({state_dbg, req_if.req_ready, req_if.resp_valid, req_if.resp_err, req_if.resp_rdata,
           bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata} !==
          {IDLE, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0})
         begin failures++; $display("FAIL reset_in_wr state=%0d rv=%b we=%b addr=%0d", state_dbg,
                                    req_if.resp_valid, bus_if.mem_we, bus_if.mem_addr); end
      rst = 1'b0;
      drive_req(1'b0, 2'd2, 32'h18, 32'h0, 1'b0, waited);
      @(negedge clk);
      checks++;
      if (state_dbg !== RD_CAP)
         begin failures++; $display("FAIL in_rd_cap got=%0d exp=%0d", state_dbg, RD_CAP); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({state_dbg, req_if.req_ready, req_if.resp_valid, req_if.resp_err, req_if.resp_rdata,
           bus_if.mem_addr, bus_if.mem_we, bus_if.mem_wdata} !==
          {IDLE, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0})
         begin failures++; $display("FAIL reset_in_rd_cap state=%0d rv=%b rd=%h", state_dbg,
                                    req_if.resp_valid, req_if.resp_rdata); end
      rst = 1'b0;
      drive_req(1'b0, 2'd2, 32'h1C, 32'h0, 1'b1, waited);            // untouched word
      collect_resp(0);
   endtask

   task automatic test_random();
      int          waited;
      int          pick;
      logic [1:0]  size;
      logic [1:0]  lane;
      logic [31:0] addr;
      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(0, 9));
         size = (pick < 5) ? 2'd2 : (pick < 7) ? 2'd0 : (pick < 9) ? 2'd1 : 2'd3;
         lane = (size == 2'd2) ? 2'b00 : (size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0}
                                                        : 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) lane = 2'($urandom_range(0, 3));
         addr = (32'($urandom_range(0, 15)) << 2) | 32'(lane);
         if ($urandom_range(0, 9) == 0) addr = addr | 32'h100;
         drive_req(1'($urandom_range(0, 1)), size, addr, $urandom, 1'b1, waited);
         collect_resp(int'($urandom_range(0, 2)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      req_if.req_valid  = 1'b0;
      req_if.req_we     = 1'b0;
      req_if.req_size   = 2'd2;
      req_if.req_addr   = 32'h0;
      req_if.req_wdata  = 32'h0;
      req_if.resp_ready = 1'b1;
      for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      test_reset();
      test_word_store_load();
      test_errors();
`ifdef MEM_ACCESS_BYTE_SIZE_EN
      test_byte_size();
`endif
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
